micro_keyed_xform: RTL and testbench

- Parametrised successor of the fixed-constant micro-tile XOR project.
- Registered transform of an input word through a DEPTH-stage valid-tagged pipeline.
- Runtime-loadable key and four selectable modes: XOR, ADD, LFSR keystream XOR, bypass.
- Sits inside a micro tile between the tile's dedicated inputs and outputs. The tile wrapper maps ui_in/uo_out bits onto these ports.

---
 rtl/micro_pkg.sv | 17 +
 rtl/micro_lfsr.sv | 46 ++++
 rtl/micro_keyed_xform.sv | 102 ++++++++++
 tb/tb_micro_keyed_xform.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the keyed micro-tile transform.
//   mode_e           : per-word transform selector carried on the 2-bit mode port
//   KEY_RESET_DEF    : default key / keystream seed after reset
//   TAPS_DEF         : default Galois LFSR feedback mask
package micro_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_BYP  = 2'd3
  } mode_e;

  localparam logic [7:0] KEY_RESET_DEF = 8'h42;
  localparam logic [7:0] TAPS_DEF      = 8'hB8;

endpackage

// File: rtl/micro_lfsr.sv
// Galois right-shift LFSR used as the keystream source.
//   clk, rst  : clock, asynchronous active-high reset (state -> SEED, or 1 if SEED is 0)
//   load      : replace state with load_val (zero forced to 1); wins over advance
//   load_val  : new seed
//   advance   : step the register once
//   state     : current keystream value
module micro_lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(micro_pkg::TAPS_DEF),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(micro_pkg::KEY_RESET_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  // An all-zero state would lock the register, so zero seeds become 1.
  function automatic logic [WIDTH-1:0] nonzero_seed(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = nonzero_seed(load_val);
    end else if (advance) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= nonzero_seed(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/micro_keyed_xform.sv
// Keyed word transform behind a DEPTH-stage valid-tagged pipeline.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : in_data carries a word to transform this cycle
//   in_data     : data word, or new key when key_load=1
//   key_load    : load in_data as key and LFSR seed; drops a coincident in_valid
//   mode        : 0=XOR key, 1=ADD key, 2=XOR LFSR keystream, 3=bypass
//   out_valid   : one-cycle pulse per transformed word
//   out_data    : last transformed word (held between pulses)
//   lfsr_state  : current keystream value
module micro_keyed_xform
  import micro_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] KEY_RESET = WIDTH'(KEY_RESET_DEF),
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             key_load,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] lfsr_state
);

  logic             accept;
  mode_e            mode_sel;
  logic [WIDTH-1:0] key_q, key_d;

  logic [WIDTH-1:0] stg_data_q  [DEPTH];
  logic [WIDTH-1:0] stg_data_d  [DEPTH];
  logic             stg_valid_q [DEPTH];
  logic             stg_valid_d [DEPTH];

  assign accept   = in_valid & ~key_load;
  assign mode_sel = mode_e'(mode);

  function automatic logic [WIDTH-1:0] xform(input mode_e            m,
                                             input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] k,
                                             input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_XOR:  r = d ^ k;
      MODE_ADD:  r = d + k;
      MODE_LFSR: r = d ^ s;
      default:   r = d;
    endcase
    return r;
  endfunction

  micro_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (KEY_RESET)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (key_load),
    .load_val (in_data),
    .advance  (accept && (mode_sel == MODE_LFSR)),
    .state    (lfsr_state)
  );

  always_comb begin
    key_d = key_load ? in_data : key_q;
  end

  // Each stage loads only when a valid word arrives, so the final stage
  // naturally holds the last result between pulses without an extra register.
  always_comb begin
    stg_valid_d[0] = accept;
    stg_data_d[0]  = accept ? xform(mode_sel, in_data, key_q, lfsr_state) : stg_data_q[0];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stg_valid_d[k] = stg_valid_q[k-1];
      stg_data_d[k]  = stg_valid_q[k-1] ? stg_data_q[k-1] : stg_data_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= KEY_RESET;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stg_valid_q[k] <= 1'b0;
        stg_data_q[k]  <= '0;
      end
    end else begin
      key_q <= key_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stg_valid_q[k] <= stg_valid_d[k];
        stg_data_q[k]  <= stg_data_d[k];
      end
    end
  end

  assign out_valid = stg_valid_q[DEPTH-1];
  assign out_data  = stg_data_q[DEPTH-1];

endmodule

// File: tb/tb_micro_keyed_xform.sv
module tb_micro_keyed_xform;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam logic [W-1:0] KR = 8'h42;
  localparam logic [W-1:0] TP = 8'hB8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         key_load = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [W-1:0] lfsr_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  micro_keyed_xform #(
    .WIDTH     (W),
    .DEPTH     (D),
    .KEY_RESET (KR),
    .TAPS      (TP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .key_load   (key_load),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .lfsr_state (lfsr_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int unsigned  due;
    logic [W-1:0] val;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] m_key, m_lfsr, m_last, mv;
  logic [W:0]   msum;
  int unsigned  cyc = 0;

  function automatic logic [W-1:0] seed_of(input logic [W-1:0] v);
    return (v == 0) ? W'(1) : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_key  = KR;
      m_lfsr = seed_of(KR);
      m_last = '0;
    end else begin
      cyc++;
      if (key_load) begin
        m_key  = in_data;
        m_lfsr = seed_of(in_data);
      end else if (in_valid) begin
        case (mode)
          2'd0: mv = in_data ^ m_key;
          2'd1: begin
            msum = {1'b0, in_data} + {1'b0, m_key};
            mv   = msum[W-1:0];
          end
          2'd2: mv = in_data ^ m_lfsr;
          default: mv = in_data;
        endcase
        if (mode == 2'd2)
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TP : W'(0));
        exp_q.push_back('{due: cyc + D - 1, val: mv});
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
    end else begin
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.val));
        m_last = e.val;
      end else begin
        chk("out_hold", 32'(out_data), 32'(m_last));
      end
      if (out_valid) obs_q.push_back(out_data);
      chk("lfsr_state", 32'(lfsr_state), 32'(m_lfsr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic v, input logic kl, input logic [W-1:0] d, input logic [1:0] m);
    @(negedge clk);
    in_valid = v;
    key_load = kl;
    in_data  = d;
    mode     = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      key_load = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    key_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: default key, latency, async reset
    drv(1'b1, 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h42);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: key load, XOR, dropped word on simultaneous load
    obs_q.delete();
    drv(1'b0, 1'b1, 8'h5A, 2'd0);
    drv(1'b1, 1'b0, 8'hFF, 2'd0);
    drv(1'b1, 1'b1, 8'h5A, 2'd0);
    idle(4);
    chk("t2_count", 32'(obs_q.size()), 32'd1);
    chk("t2_xor", 32'(obs_q[0]), 32'hA5);

    // 3: ADD, including wrap and a key load behind an in-flight word
    obs_q.delete();
    drv(1'b0, 1'b1, 8'h42, 2'd0);
    drv(1'b1, 1'b0, 8'hC0, 2'd1);
    drv(1'b0, 1'b1, 8'h01, 2'd0);
    drv(1'b1, 1'b0, 8'hFF, 2'd1);
    idle(4);
    chk("t3_count", 32'(obs_q.size()), 32'd2);
    chk("t3_add", 32'(obs_q[0]), 32'h02);
    chk("t3_wrap", 32'(obs_q[1]), 32'h00);

    // 4: keystream, with an interleaved XOR word
    pulse_reset();
    obs_q.delete();
    drv(1'b1, 1'b0, 8'h00, 2'd2);
    drv(1'b1, 1'b0, 8'h00, 2'd2);
    drv(1'b1, 1'b0, 8'h00, 2'd2);
    drv(1'b1, 1'b0, 8'h00, 2'd0);
    drv(1'b1, 1'b0, 8'h00, 2'd2);
    idle(4);
    chk("t4_count", 32'(obs_q.size()), 32'd5);
    chk("t4_ks0", 32'(obs_q[0]), 32'h42);
    chk("t4_ks1", 32'(obs_q[1]), 32'h21);
    chk("t4_ks2", 32'(obs_q[2]), 32'hA8);
    chk("t4_xor", 32'(obs_q[3]), 32'h42);
    chk("t4_ks3", 32'(obs_q[4]), 32'h54);
    chk("t4_lfsr_after", 32'(lfsr_state), 32'h2A);

    // 5: zero seed and bypass
    obs_q.delete();
    drv(1'b0, 1'b1, 8'h00, 2'd0);
    @(negedge clk);
    key_load = 1'b0;
    chk("t5_zero_seed", 32'(lfsr_state), 32'h01);
    drv(1'b1, 1'b0, 8'h3C, 2'd3);
    drv(1'b1, 1'b0, 8'h00, 2'd0);
    idle(4);
    chk("t5_count", 32'(obs_q.size()), 32'd2);
    chk("t5_bypass", 32'(obs_q[0]), 32'h3C);
    chk("t5_key_kept", 32'(obs_q[1]), 32'h00);

    // 6: reset flushes in-flight words; mode sampled at accept
    obs_q.delete();
    drv(1'b1, 1'b0, 8'h11, 2'd0);
    drv(1'b1, 1'b0, 8'h22, 2'd0);
    pulse_reset();
    idle(4);
    chk("t6_flushed", 32'(obs_q.size()), 32'd0);
    drv(1'b1, 1'b0, 8'h00, 2'd0);
    drv(1'b1, 1'b0, 8'h0F, 2'd1);
    drv(1'b0, 1'b0, 8'h00, 2'd0);
    idle(4);
    chk("t6_count", 32'(obs_q.size()), 32'd2);
    chk("t6_key_reset", 32'(obs_q[0]), 32'h42);
    chk("t6_mode_at_accept", 32'(obs_q[1]), 32'h51);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        drv(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0),
            W'($urandom),
            2'($urandom_range(0, 3)));
      end
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
